star_spawner: RTL and testbench
===============================

# star_spawner

Downstream consumer of the periodic star-placement pulse. Each `put_star` pulse claims a free slot in a small fixed pool of falling stars and gives it a pseudo-random horizontal position. Every frame tick moves all live stars down the screen, and any star that passes the bottom limit is retired. The flattened per-slot outputs feed the star drawing and collision logic.

## Interface
- `NUM_STARS`, 4: number of star slots (2..8).
- `X_BITS`, 11: width of x coordinate.
- `Y_BITS`, 11: width of y coordinate.
- `X_MIN`, 64: left offset added to the random x value.
- `X_RAND_BITS`, 9: number of LFSR bits used for x. Range is X_MIN..X_MIN+2^X_RAND_BITS-1.
- `Y_START`, 0: y value loaded on spawn.
- `Y_LIMIT`, 479: last visible row.
- `SPEED`, 2: rows advanced per frame tick.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `put_star`, in, 1: one-cycle spawn request from the star-placement pulse generator.
- `startOfFrame`, in, 1: one-cycle frame tick.
- `kill_mask`, in, NUM_STARS: a 1 retires that slot (collision).
- `star_active`, out, NUM_STARS: slot live flags.
- `star_x`, out, NUM_STARS*X_BITS: slot i occupies bits [i*X_BITS +: X_BITS].
- `star_y`, out, NUM_STARS*Y_BITS: slot i occupies bits [i*Y_BITS +: Y_BITS].
- `spawn_drop`, out, 1: one-cycle pulse when a request finds no free slot.
- `drop_count`, out, 8: saturating count of dropped requests.

## Operation
- **Reset values:**
  - `star_active` = 0, all `star_x` = 0, all `star_y` = 0.
  - `spawn_drop` = 0, `drop_count` = 0.
  - LFSR = 16'hACE1.
- **LFSR:**
  - 16-bit Galois LFSR that advances every clock.
  - Next value: if `lfsr[0]`, next = (lfsr>>1) ^ 16'hB400; otherwise next = lfsr>>1.
  - It never reaches 0.
- **Per-slot state machine:** two states, IDLE (`star_active`=0) and FALLING (`star_active`=1).
  - IDLE -> FALLING on spawn into this slot.
  - FALLING -> IDLE when the kill bit is set, or when the star leaves the screen.
- **Spawn:**
  - When `put_star`=1, the target is the lowest-index slot that is IDLE in the registered state **and** has its `kill_mask` bit at 0 this cycle.
  - On the next edge the target slot gets `star_x` = X_MIN + lfsr[X_RAND_BITS-1:0] (current registered LFSR value), `star_y` = Y_START, active = 1.
  - Width rule: the sum is computed in X_BITS and X_MIN+2^X_RAND_BITS-1 must fit in X_BITS.
- **Full pool:** if no eligible slot exists, no slot changes, `spawn_drop` pulses for one cycle, and `drop_count` increments, saturating at 255.
- **Advance:** on `startOfFrame`, every FALLING slot that is not being killed and not being spawned this cycle computes y+SPEED in Y_BITS+1 bits.
  - If the result is > Y_LIMIT, the slot goes IDLE and `star_y` holds its old value.
  - Otherwise `star_y` takes the new value.
- **Kill:** a kill bit on a FALLING slot sets it IDLE at the next edge, with x and y held. A kill bit on an IDLE slot has no effect.
- Retired slots keep their last x and y. Consumers use only `star_active`.

## Timing
- Spawn latency is 1 cycle: request at edge n is visible on `star_active`/`star_x`/`star_y` after edge n+1.
- **Spawn and `startOfFrame` in the same cycle:** the new star appears at Y_START and is not advanced that frame. Other slots advance normally.
- **Kill and spawn on the same slot in the same cycle:** the slot is not eligible, so the spawn goes to the next free slot. If none is free, the request is dropped.
- **Kill and `startOfFrame` on the same slot:** the kill wins and the slot goes IDLE.
- Only one spawn is accepted per cycle. `put_star` held high spawns one star per cycle until the pool is full, then drops every cycle.
- Reset mid-operation clears every slot and the drop counter immediately (asynchronous), and restarts the LFSR at 16'hACE1.

## Test plan
1. **First spawn and LFSR step:** release reset, then assert `put_star` in the first cycle. Expect slot 0 active with x = 64+225 = 289, y = 0. The LFSR must read 16'hE270 after one clock.
2. **Fall and retire:** with one star at y=0, issue 239 frame ticks. Expect y = 478 and still active. The 240th tick (480 > 479) must clear `star_active[0]` with y held at 478.
3. **Pool full:** hold `put_star` for 6 cycles with NUM_STARS=4. Expect slots 0..3 filled in order and two `spawn_drop` pulses, leaving `drop_count` = 2. Then 300 further drops must saturate `drop_count` at 255.
4. **Kill/spawn race:**
   - Fill slots 0..3, then assert `kill_mask`=4'b0010 together with `put_star`. Expect slot 1 to go IDLE and the request to be dropped.
   - Repeat `put_star` on the next cycle. Expect slot 1 to be respawned.
5. **Simultaneous events:** a star sits in slot 0 at y=10. Assert `startOfFrame` and `put_star` in the same cycle. Expect slot 0 at y=12 and slot 1 at y=0.
6. **Mid-operation reset:** with 3 stars active and `drop_count`=5, pulse `reset` mid-cycle. All outputs must read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/star_spawner.sv
// star_spawner
//   Manages a small fixed pool of falling stars. A put_star pulse claims the
//   lowest free slot and places it at a pseudo-random x (from a free-running
//   16-bit Galois LFSR) and at Y_START. Each startOfFrame tick moves every live
//   star down by SPEED rows. A star that would pass Y_LIMIT is retired.
//   kill_mask retires slots on collision. A request that finds no free slot is
//   dropped and counted.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   put_star     in   one-cycle spawn request
//   startOfFrame in   one-cycle frame tick
//   kill_mask    in   per-slot retire request (collision)
//   star_active  out  per-slot live flags
//   star_x       out  flattened x, slot i at [i*X_BITS +: X_BITS]
//   star_y       out  flattened y, slot i at [i*Y_BITS +: Y_BITS]
//   spawn_drop   out  one-cycle pulse when a request is dropped
//   drop_count   out  saturating count of dropped requests
module star_spawner #(
  parameter int NUM_STARS   = 4,
  parameter int X_BITS      = 11,
  parameter int Y_BITS      = 11,
  parameter int X_MIN       = 64,
  parameter int X_RAND_BITS = 9,
  parameter int Y_START     = 0,
  parameter int Y_LIMIT     = 479,
  parameter int SPEED       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          put_star,
  input  logic                          startOfFrame,
  input  logic [NUM_STARS-1:0]          kill_mask,
  output logic [NUM_STARS-1:0]          star_active,
  output logic [NUM_STARS*X_BITS-1:0]   star_x,
  output logic [NUM_STARS*Y_BITS-1:0]   star_y,
  output logic                          spawn_drop,
  output logic [7:0]                    drop_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FALL = 1'b1
  } state_e;

  localparam logic [15:0]       LFSR_SEED = 16'hACE1;
  localparam logic [15:0]       LFSR_TAPS = 16'hB400;
  localparam logic [X_BITS-1:0] X_MIN_V   = X_BITS'(X_MIN);
  localparam logic [Y_BITS-1:0] Y_START_V = Y_BITS'(Y_START);
  localparam logic [Y_BITS:0]   Y_LIMIT_V = (Y_BITS+1)'(Y_LIMIT);
  localparam logic [Y_BITS:0]   SPEED_V   = (Y_BITS+1)'(SPEED);

  state_e              state_q [NUM_STARS];
  state_e              state_d [NUM_STARS];
  logic [X_BITS-1:0]   x_q     [NUM_STARS];
  logic [X_BITS-1:0]   x_d     [NUM_STARS];
  logic [Y_BITS-1:0]   y_q     [NUM_STARS];
  logic [Y_BITS-1:0]   y_d     [NUM_STARS];
  logic [15:0]         lfsr_q;
  logic [15:0]         lfsr_d;
  logic                drop_q;
  logic                drop_d;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_d;

  logic [NUM_STARS-1:0] target_s;
  logic                 found_s;
  logic [X_BITS-1:0]    spawn_x_s;
  logic [Y_BITS:0]      y_sum_s;

  // Next-state logic: LFSR step, slot selection, per-slot FSM, drop counter.
  always_comb begin
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    spawn_x_s = X_MIN_V + {{(X_BITS-X_RAND_BITS){1'b0}}, lfsr_q[X_RAND_BITS-1:0]};
    target_s  = '0;
    found_s   = 1'b0;
    y_sum_s   = '0;

    // A slot being killed this cycle is not eligible, even if it is idle.
    for (int i = 0; i < NUM_STARS; i++) begin
      if (!found_s && (state_q[i] == S_IDLE) && !kill_mask[i]) begin
        target_s[i] = 1'b1;
        found_s     = 1'b1;
      end else begin
        target_s[i] = target_s[i];
      end
    end

    for (int i = 0; i < NUM_STARS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      y_sum_s    = {1'b0, y_q[i]} + SPEED_V;
      case (state_q[i])
        S_IDLE: begin
          // Only idle slots are spawn targets, so a fresh star never advances
          // in the frame it is born.
          if (put_star && target_s[i]) begin
            state_d[i] = S_FALL;
            x_d[i]     = spawn_x_s;
            y_d[i]     = Y_START_V;
          end else begin
            state_d[i] = S_IDLE;
          end
        end
        S_FALL: begin
          if (kill_mask[i]) begin
            state_d[i] = S_IDLE;
          end else if (startOfFrame) begin
            // Retire with y held rather than wrapping past the limit.
            if (y_sum_s > Y_LIMIT_V) begin
              state_d[i] = S_IDLE;
            end else begin
              y_d[i] = y_sum_s[Y_BITS-1:0];
            end
          end else begin
            state_d[i] = S_FALL;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end

    drop_d = put_star && !found_s;
    if (drop_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STARS; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      lfsr_q <= LFSR_SEED;
      drop_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_STARS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      lfsr_q <= lfsr_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_STARS; g++) begin : g_flat
      assign star_active[g]             = (state_q[g] == S_FALL);
      assign star_x[g*X_BITS +: X_BITS] = x_q[g];
      assign star_y[g*Y_BITS +: Y_BITS] = y_q[g];
    end
  endgenerate

  assign spawn_drop = drop_q;
  assign drop_count = cnt_q;

endmodule

// File: tb/tb_star_spawner.sv
// Directed testbench for star_spawner (default parameters).
module tb_star_spawner;

  logic        clk;
  logic        reset;
  logic        put_star;
  logic        startOfFrame;
  logic [3:0]  kill_mask;
  logic [3:0]  star_active;
  logic [43:0] star_x;
  logic [43:0] star_y;
  logic        spawn_drop;
  logic [7:0]  drop_count;

  int tests_run;
  int tests_failed;

  star_spawner dut (
    .clk          (clk),
    .reset        (reset),
    .put_star     (put_star),
    .startOfFrame (startOfFrame),
    .kill_mask    (kill_mask),
    .star_active  (star_active),
    .star_x       (star_x),
    .star_y       (star_y),
    .spawn_drop   (spawn_drop),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset is asserted for one full cycle and released at a negedge, so the
  // next posedge is the first cycle with LFSR = 16'hACE1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; put_star = 1'b0; startOfFrame = 1'b0; kill_mask = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; put_star = 1'b0; startOfFrame = 1'b0; kill_mask = 4'b0000;
    #12;
    tests_run++;
    if ((star_active !== 4'b0000) || (star_x !== 44'd0) || (star_y !== 44'd0) ||
        (spawn_drop !== 1'b0) || (drop_count !== 8'd0)) begin
      tests_failed++;
      $display("FAIL reset_outputs: act=%b x=%h y=%h drop=%b cnt=%0d, want all 0",
               star_active, star_x, star_y, spawn_drop, drop_count);
    end
    tests_run++;
    if (dut.lfsr_q !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_q);
    end
  endtask

  // First spawn, then 240 frame ticks to reach the bottom limit.
  task automatic test_spawn_and_fall();
    do_reset();
    put_star = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b0001) || (star_x[10:0] !== 11'd289) || (star_y[10:0] !== 11'd0)) begin
      tests_failed++;
      $display("FAIL first_spawn: act=%b x0=%0d y0=%0d, want 0001/289/0",
               star_active, star_x[10:0], star_y[10:0]);
    end
    tests_run++;
    if (dut.lfsr_q !== 16'hE270) begin
      tests_failed++;
      $display("FAIL lfsr_step: got %h want e270", dut.lfsr_q);
    end
    @(negedge clk);
    put_star = 1'b0; startOfFrame = 1'b1;
    repeat (239) @(posedge clk);
    #1;
    tests_run++;
    if ((star_active !== 4'b0001) || (star_y[10:0] !== 11'd478)) begin
      tests_failed++;
      $display("FAIL fall_239: act=%b y0=%0d, want 0001/478", star_active, star_y[10:0]);
    end
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b0000) || (star_y[10:0] !== 11'd478) || (star_x[10:0] !== 11'd289)) begin
      tests_failed++;
      $display("FAIL retire_240: act=%b y0=%0d x0=%0d, want 0000/478/289",
               star_active, star_y[10:0], star_x[10:0]);
    end
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  // Six back-to-back requests into a four-slot pool, then saturation.
  task automatic test_pool_full();
    logic [3:0] exp_act [6];
    logic       exp_drp [6];
    logic [7:0] exp_cnt [6];
    exp_act = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    exp_drp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_cnt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    do_reset();
    put_star = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ((star_active !== exp_act[c]) || (spawn_drop !== exp_drp[c]) || (drop_count !== exp_cnt[c])) begin
        tests_failed++;
        $display("FAIL pool_cycle%0d: act=%b drop=%b cnt=%0d, want %b/%b/%0d",
                 c, star_active, spawn_drop, drop_count, exp_act[c], exp_drp[c], exp_cnt[c]);
      end
    end
    // x = 64 + low 9 bits of ACE1, E270, 7138, 389C
    tests_run++;
    if ((star_x[10:0] !== 11'd289) || (star_x[21:11] !== 11'd176) ||
        (star_x[32:22] !== 11'd376) || (star_x[43:33] !== 11'd220)) begin
      tests_failed++;
      $display("FAIL pool_x: x=%0d,%0d,%0d,%0d want 289,176,376,220",
               star_x[10:0], star_x[21:11], star_x[32:22], star_x[43:33]);
    end
    repeat (300) @(posedge clk);
    #1;
    tests_run++;
    if ((drop_count !== 8'd255) || (spawn_drop !== 1'b1) || (star_active !== 4'b1111)) begin
      tests_failed++;
      $display("FAIL drop_saturate: cnt=%0d drop=%b act=%b want 255/1/1111",
               drop_count, spawn_drop, star_active);
    end
  endtask

  // Runs on the full pool left by test_pool_full.
  task automatic test_kill_race();
    @(negedge clk);
    put_star = 1'b1; kill_mask = 4'b0010;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b1101) || (spawn_drop !== 1'b1) || (drop_count !== 8'd255)) begin
      tests_failed++;
      $display("FAIL kill_spawn_race: act=%b drop=%b cnt=%0d want 1101/1/255",
               star_active, spawn_drop, drop_count);
    end
    @(negedge clk);
    kill_mask = 4'b0000;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b1111) || (spawn_drop !== 1'b0) || (star_y[21:11] !== 11'd0)) begin
      tests_failed++;
      $display("FAIL respawn_slot1: act=%b drop=%b y1=%0d want 1111/0/0",
               star_active, spawn_drop, star_y[21:11]);
    end
    @(negedge clk);
    put_star = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    put_star = 1'b1;
    @(posedge clk);
    @(negedge clk);
    put_star = 1'b0; startOfFrame = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (star_y[10:0] !== 11'd10) begin
      tests_failed++;
      $display("FAIL pre_sim_y: y0=%0d want 10", star_y[10:0]);
    end
    @(negedge clk);
    put_star = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b0011) || (star_y[10:0] !== 11'd12) || (star_y[21:11] !== 11'd0)) begin
      tests_failed++;
      $display("FAIL spawn_with_frame: act=%b y0=%0d y1=%0d want 0011/12/0",
               star_active, star_y[10:0], star_y[21:11]);
    end
    @(negedge clk);
    put_star = 1'b0; kill_mask = 4'b0001;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b0010) || (star_y[10:0] !== 11'd12) || (star_y[21:11] !== 11'd2)) begin
      tests_failed++;
      $display("FAIL kill_with_frame: act=%b y0=%0d y1=%0d want 0010/12/2",
               star_active, star_y[10:0], star_y[21:11]);
    end
    @(negedge clk);
    kill_mask = 4'b0000; startOfFrame = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    put_star = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    tests_run++;
    if ((star_active !== 4'b1111) || (drop_count !== 8'd5)) begin
      tests_failed++;
      $display("FAIL pre_reset_fill: act=%b cnt=%0d want 1111/5", star_active, drop_count);
    end
    @(negedge clk);
    put_star = 1'b0; kill_mask = 4'b1000;
    @(posedge clk); #1;
    tests_run++;
    if ((star_active !== 4'b0111) || (drop_count !== 8'd5) || (spawn_drop !== 1'b0)) begin
      tests_failed++;
      $display("FAIL pre_reset_kill: act=%b cnt=%0d drop=%b want 0111/5/0",
               star_active, drop_count, spawn_drop);
    end
    @(negedge clk);
    kill_mask = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ((star_active !== 4'b0000) || (star_x !== 44'd0) || (star_y !== 44'd0) ||
        (spawn_drop !== 1'b0) || (drop_count !== 8'd0)) begin
      tests_failed++;
      $display("FAIL async_reset: act=%b x=%h y=%h drop=%b cnt=%0d want all 0",
               star_active, star_x, star_y, spawn_drop, drop_count);
    end
    tests_run++;
    if (dut.lfsr_q !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL async_reset_lfsr: got %h want ace1", dut.lfsr_q);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_spawn_and_fall();
    test_pool_full();
    test_kill_race();
    test_simultaneous();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
